dispatch_unit: RTL

DISPATCH_UNIT -- requirements
Module: dispatch_unit

---
 rtl/dispatch_unit.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dispatch_unit.sv
// dispatch_unit: decodes one RV32I instruction per accepted fetch handshake,
// resolves its two source operands (RF -> ROB -> CDB forwarding) and presents
// a one-cycle issue packet to the ROB, the reservation station and the
// load/store buffer.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable)
//   inst_valid/inst/inst_addr/inst_ready : fetch handshake
//   rs1_id/rs2_id, rs*_val, rs*_has_dep, rs*_dep : register file lookup
//   rob_qry*_id/_fi/_value : ROB lookup for dependent operands
//   cdb_valid/cdb_rob_id/cdb_value : packed broadcast buses (bus k in slice k)
//   rob_full/rs_full/lsb_full/rob_clear/rob_tail_id : back-pressure, flush, tail
//   rob_*, rs_*, lsb_*, op_* : registered issue outputs
module dispatch_unit #(
  parameter int ROB_SIZE_BIT = 4,
  parameter int CDB_NUM      = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            inst_valid,
  input  logic [31:0]                     inst,
  input  logic [31:0]                     inst_addr,
  output logic                            inst_ready,
  output logic [4:0]                      rs1_id,
  output logic [4:0]                      rs2_id,
  input  logic [31:0]                     rs1_val,
  input  logic [31:0]                     rs2_val,
  input  logic                            rs1_has_dep,
  input  logic                            rs2_has_dep,
  input  logic [ROB_SIZE_BIT-1:0]         rs1_dep,
  input  logic [ROB_SIZE_BIT-1:0]         rs2_dep,
  output logic [ROB_SIZE_BIT-1:0]         rob_qry1_id,
  output logic [ROB_SIZE_BIT-1:0]         rob_qry2_id,
  input  logic                            rob_qry1_fi,
  input  logic                            rob_qry2_fi,
  input  logic [31:0]                     rob_qry1_value,
  input  logic [31:0]                     rob_qry2_value,
  input  logic [CDB_NUM-1:0]              cdb_valid,
  input  logic [CDB_NUM*ROB_SIZE_BIT-1:0] cdb_rob_id,
  input  logic [CDB_NUM*32-1:0]           cdb_value,
  input  logic                            rob_full,
  input  logic                            rs_full,
  input  logic                            lsb_full,
  input  logic                            rob_clear,
  input  logic [ROB_SIZE_BIT-1:0]         rob_tail_id,
  output logic                            rob_input,
  output logic [2:0]                      rob_type,
  output logic [4:0]                      rob_reg_id,
  output logic [31:0]                     rob_value,
  output logic [31:0]                     rob_addr,
  output logic                            rob_fi,
  output logic                            rs_input,
  output logic [4:0]                      rs_type,
  output logic                            lsb_input,
  output logic [3:0]                      lsb_type,
  output logic [31:0]                     op_r1_val,
  output logic [31:0]                     op_r2_val,
  output logic [31:0]                     op_imm,
  output logic                            op_r1_has_dep,
  output logic                            op_r2_has_dep,
  output logic [ROB_SIZE_BIT-1:0]         op_r1_dep,
  output logic [ROB_SIZE_BIT-1:0]         op_r2_dep,
  output logic [ROB_SIZE_BIT-1:0]         op_rob_id
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       accept;

  assign opc         = inst[6:0];
  assign f3          = inst[14:12];
  assign inst_ready  = rdy_in & ~rst_in & ~rob_full & ~rs_full & ~lsb_full & ~rob_clear;
  assign accept      = inst_valid & inst_ready;
  assign rs1_id      = inst[19:15];
  assign rs2_id      = inst[24:20];
  assign rob_qry1_id = rs1_dep;
  assign rob_qry2_id = rs2_dep;

  // Immediate formats
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};

  // Decode
  logic        d_known, d_rs, d_lsb, d_fi;
  logic [1:0]  d_use;
  logic [2:0]  d_rtype;
  logic [31:0] d_imm, d_fval;
  logic        d_b0;
  logic [4:0]  d_reg;

  always_comb begin
    d_known = 1'b0;
    d_rs    = 1'b0;
    d_lsb   = 1'b0;
    d_fi    = 1'b0;
    d_use   = 2'b00;
    d_rtype = 3'd0;
    d_imm   = '0;
    d_fval  = '0;
    case (opc)
      OPC_OP:     begin d_known = 1'b1; d_rs = 1'b1; d_use = 2'b11; end
      OPC_OPIMM:  begin d_known = 1'b1; d_rs = 1'b1; d_use = 2'b01; d_imm = imm_i; end
      OPC_LOAD:   begin d_known = 1'b1; d_lsb = 1'b1; d_use = 2'b01; d_rtype = 3'd4; d_imm = imm_i; end
      OPC_STORE:  begin d_known = 1'b1; d_lsb = 1'b1; d_use = 2'b11; d_rtype = 3'd1; d_imm = imm_s; end
      OPC_BRANCH: begin d_known = 1'b1; d_rs = 1'b1; d_use = 2'b11; d_rtype = 3'd2; d_imm = imm_b; end
      OPC_JALR:   begin d_known = 1'b1; d_rs = 1'b1; d_use = 2'b01; d_rtype = 3'd3; d_imm = imm_i; end
      OPC_JAL:    begin d_known = 1'b1; d_rtype = 3'd5; d_imm = imm_j; d_fi = 1'b1; d_fval = inst_addr + 32'd4; end
      OPC_LUI:    begin d_known = 1'b1; d_rtype = 3'd5; d_imm = imm_u; d_fi = 1'b1; d_fval = imm_u; end
      OPC_AUIPC:  begin d_known = 1'b1; d_rtype = 3'd5; d_imm = imm_u; d_fi = 1'b1; d_fval = inst_addr + imm_u; end
      default: ;
    endcase
    // inst[30] selects SUB/SRA for register ops and SRAI for shift-immediates
    d_b0  = ((opc == OPC_OP) || (opc == OPC_OPIMM && f3 == 3'b101)) ? inst[30] : 1'b0;
    d_reg = (d_rtype == 3'd1 || d_rtype == 3'd2) ? 5'd0 : inst[11:7];
  end

  // Operand resolution, operand 0 = rs1, operand 1 = rs2
  logic [1:0]                   o_hd, o_qfi, r_has;
  logic [1:0][ROB_SIZE_BIT-1:0] o_dep, r_dep;
  logic [1:0][31:0]             o_rfv, o_qv, r_val;

  assign o_hd  = {rs2_has_dep, rs1_has_dep};
  assign o_qfi = {rob_qry2_fi, rob_qry1_fi};
  assign o_dep = {rs2_dep, rs1_dep};
  assign o_rfv = {rs2_val, rs1_val};
  assign o_qv  = {rob_qry2_value, rob_qry1_value};

  always_comb begin
    for (int o = 0; o < 2; o++) begin
      r_val[o] = '0;
      r_has[o] = 1'b0;
      r_dep[o] = '0;
      if (d_use[o]) begin
        if (!o_hd[o]) r_val[o] = o_rfv[o];
        else if (o_qfi[o]) r_val[o] = o_qv[o];
        else begin
          r_has[o] = 1'b1;
          r_dep[o] = o_dep[o];
          // scan high to low so the lowest-index matching bus wins
          for (int k = CDB_NUM - 1; k >= 0; k--) begin
            if (cdb_valid[k] && cdb_rob_id[k*ROB_SIZE_BIT +: ROB_SIZE_BIT] == o_dep[o]) begin
              r_has[o] = 1'b0;
              r_dep[o] = '0;
              r_val[o] = cdb_value[k*32 +: 32];
            end
          end
        end
      end
    end
  end

  // Issue register: loads on accept, drops strobes on any other enabled cycle
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rob_input     <= 1'b0;
      rs_input      <= 1'b0;
      lsb_input     <= 1'b0;
      rob_type      <= '0;
      rob_reg_id    <= '0;
      rob_value     <= '0;
      rob_addr      <= '0;
      rob_fi        <= 1'b0;
      rs_type       <= '0;
      lsb_type      <= '0;
      op_r1_val     <= '0;
      op_r2_val     <= '0;
      op_imm        <= '0;
      op_r1_has_dep <= 1'b0;
      op_r2_has_dep <= 1'b0;
      op_r1_dep     <= '0;
      op_r2_dep     <= '0;
      op_rob_id     <= '0;
    end else if (rdy_in) begin
      if (accept) begin
        rob_input     <= d_known;
        rs_input      <= d_rs;
        lsb_input     <= d_lsb;
        rob_type      <= d_rtype;
        rob_reg_id    <= d_reg;
        rob_value     <= d_fval;
        rob_addr      <= inst_addr;
        rob_fi        <= d_fi;
        rs_type       <= {opc == OPC_BRANCH, f3, d_b0};
        lsb_type      <= {opc == OPC_STORE, f3};
        op_r1_val     <= r_val[0];
        op_r2_val     <= r_val[1];
        op_imm        <= d_imm;
        op_r1_has_dep <= r_has[0];
        op_r2_has_dep <= r_has[1];
        op_r1_dep     <= r_dep[0];
        op_r2_dep     <= r_dep[1];
        op_rob_id     <= rob_tail_id;
      end else begin
        rob_input <= 1'b0;
        rs_input  <= 1'b0;
        lsb_input <= 1'b0;
      end
    end
  end

endmodule
